// File: rtl/rps_pkg.sv
// Shared definitions for the rock-paper-scissors datapath: choice codes,
// scoring result codes, the button-conditioner state encoding and small
// encoding helpers.
package rps_pkg;

  // Encoded player choices
  localparam logic [1:0] NONE     = 2'd0;
  localparam logic [1:0] ROCK     = 2'd1;
  localparam logic [1:0] PAPER    = 2'd2;
  localparam logic [1:0] SCISSORS = 2'd3;

  // Round outcome codes consumed by the scoring stage
  localparam logic [1:0] RESULT_DRAW    = 2'd0;
  localparam logic [1:0] RESULT_P1_WINS = 2'd1;
  localparam logic [1:0] RESULT_P2_WINS = 2'd2;

  // Button conditioner states
  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    FIRE,
    WAIT_RELEASE,
    DB_RELEASE
  } cond_state_e;

  // Priority encode {scissors, paper, rock}; the highest button wins
  function automatic logic [1:0] encode_choice(input logic [2:0] btn);
    logic [1:0] code;
    if (btn[2]) begin
      code = SCISSORS;
    end else if (btn[1]) begin
      code = PAPER;
    end else if (btn[0]) begin
      code = ROCK;
    end else begin
      code = NONE;
    end
    return code;
  endfunction

  // True when two or more buttons are held at once
  function automatic logic is_multi_press(input logic [2:0] btn);
    return (btn[0] & btn[1]) | (btn[0] & btn[2]) | (btn[1] & btn[2]);
  endfunction

endpackage

// File: rtl/rps_sync.sv
// Multi-flop synchroniser for the raw, asynchronous player buttons.
// All stages clear on the asynchronous active-high reset.
module rps_sync #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned WIDTH  = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [STAGES-1:0][WIDTH-1:0] r_chain;

  // Shift the raw inputs through the flop chain; the oldest stage is the output
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/rps_button_conditioner.sv
// Rock-paper-scissors button conditioner: synchronises BTN1..BTN3, debounces
// press and release, and emits one CHOICE_VALID strobe per physical press.
// Optional feature macro: RPS_MULTI_PRESS_REJECT_EN -- when defined, a press
// with more than one button held pulses CHOICE_REJECT instead of firing.
module rps_button_conditioner
  import rps_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN1,
  input  logic       BTN2,
  input  logic       BTN3,
  output logic       CHOICE_VALID,
  output logic [1:0] CHOICE,
  output logic       CHOICE_REJECT,
  output logic       BUSY
);

  localparam int unsigned     CntW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [2:0]      w_sync;
  cond_state_e     r_state;
  logic [2:0]      r_snap;
  logic [CntW-1:0] r_cnt;
  logic            r_choice_valid;
  logic [1:0]      r_choice;
  logic            r_busy;
`ifdef RPS_MULTI_PRESS_REJECT_EN
  logic            r_choice_reject;
`endif

  rps_sync #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (3)
  ) u_sync (
    .i_clk (CLK),
    .i_rst (RST),
    .i_d   ({BTN3, BTN2, BTN1}),
    .o_q   (w_sync)
  );

  // Debounce FSM; strobes are loaded on the edge entering FIRE so they are
  // visible exactly while the state is FIRE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state        <= IDLE;
      r_snap         <= '0;
      r_cnt          <= '0;
      r_choice_valid <= 1'b0;
      r_choice       <= NONE;
      r_busy         <= 1'b0;
`ifdef RPS_MULTI_PRESS_REJECT_EN
      r_choice_reject <= 1'b0;
`endif
    end else begin
      r_choice_valid <= 1'b0;
`ifdef RPS_MULTI_PRESS_REJECT_EN
      r_choice_reject <= 1'b0;
`endif
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_sync != 3'b000) begin
            r_snap  <= w_sync;
            r_state <= DB_PRESS;
            r_busy  <= 1'b1;
          end
        end
        DB_PRESS: begin
          if (w_sync == 3'b000) begin
            // Glitch: drop back without a strobe
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_sync != r_snap) begin
            r_snap <= w_sync;
            r_cnt  <= '0;
          end else if (r_cnt == CntMax) begin
            r_state <= FIRE;
`ifdef RPS_MULTI_PRESS_REJECT_EN
            if (is_multi_press(r_snap)) begin
              r_choice_reject <= 1'b1;
            end else begin
              r_choice_valid <= 1'b1;
              r_choice       <= encode_choice(r_snap);
            end
`else
            r_choice_valid <= 1'b1;
            r_choice       <= encode_choice(r_snap);
`endif
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        FIRE: begin
          r_state <= WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          // Buttons held or added here are ignored until a full release
          if (w_sync == 3'b000) begin
            r_cnt   <= '0;
            r_state <= DB_RELEASE;
          end
        end
        DB_RELEASE: begin
          if (w_sync != 3'b000) begin
            r_state <= WAIT_RELEASE;
          end else if (r_cnt == CntMax) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign CHOICE_VALID = r_choice_valid;
  assign CHOICE       = r_choice;
  assign BUSY         = r_busy;
`ifdef RPS_MULTI_PRESS_REJECT_EN
  assign CHOICE_REJECT = r_choice_reject;
`else
  assign CHOICE_REJECT = 1'b0;
`endif

endmodule

// File: tb/tb_rps_button_conditioner.sv
// Self-checking bench for rps_button_conditioner (DEBOUNCE_CYCLES=4,
// SYNC_STAGES=2). A run-length model of the press/release rules is compared
// against the DUT every cycle; directed scenarios add literal expectations.
module tb_rps_button_conditioner;

  localparam int unsigned DB   = 4;
  localparam int unsigned SYNC = 2;
`ifdef RPS_MULTI_PRESS_REJECT_EN
  localparam bit RejectEn = 1'b1;
`else
  localparam bit RejectEn = 1'b0;
`endif

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       btn1 = 1'b0;
  logic       btn2 = 1'b0;
  logic       btn3 = 1'b0;
  logic       choice_valid;
  logic [1:0] choice;
  logic       choice_reject;
  logic       busy;

  rps_button_conditioner #(
    .DEBOUNCE_CYCLES (DB),
    .SYNC_STAGES     (SYNC)
  ) dut (
    .CLK           (clk),
    .RST           (rst),
    .BTN1          (btn1),
    .BTN2          (btn2),
    .BTN3          (btn3),
    .CHOICE_VALID  (choice_valid),
    .CHOICE        (choice),
    .CHOICE_REJECT (choice_reject),
    .BUSY          (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int reject_cnt = 0;
  int last_valid_cyc = -1;
  int busy_fall_cyc = -1;

  logic       m_valid  = 1'b0;
  logic       m_reject = 1'b0;
  logic       m_busy   = 1'b0;
  logic [1:0] m_choice = 2'd0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int prio(input logic [2:0] v);
    if (v[2]) return 3;
    if (v[1]) return 2;
    return 1;
  endfunction

  initial begin : edge_count
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Model: the FSM sees each raw sample SYNC edges late. While armed, a
  // nonzero value seen unchanged on DB+1 consecutive edges is accepted. Once
  // accepted, one edge is dead, then DB+1 consecutive zero edges re-arm.
  initial begin : model
    logic [2:0] hist[$];
    logic [2:0] s;
    logic [2:0] val;
    int run;
    int zrun;
    int skip;
    bit armed;
    for (int i = 0; i < SYNC; i++) hist.push_back(3'b000);
    armed = 1'b1; run = 0; zrun = 0; skip = 0; val = 3'b000;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        hist.delete();
        for (int i = 0; i < SYNC; i++) hist.push_back(3'b000);
        armed = 1'b1; run = 0; zrun = 0; skip = 0; val = 3'b000;
        m_valid = 1'b0; m_reject = 1'b0; m_busy = 1'b0; m_choice = 2'd0;
      end else begin
        s = hist.pop_front();
        hist.push_back({btn3, btn2, btn1});
        m_valid  = 1'b0;
        m_reject = 1'b0;
        if (armed) begin
          if (s == 3'b000) begin
            run = 0;
          end else if (run > 0 && s == val) begin
            run++;
          end else begin
            run = 1;
            val = s;
          end
          if (run == DB + 1) begin
            armed = 1'b0; run = 0; skip = 1; zrun = 0;
            if (RejectEn && $countones(val) > 1) begin
              m_reject = 1'b1;
            end else begin
              m_valid  = 1'b1;
              m_choice = 2'(prio(val));
            end
          end
        end else if (skip > 0) begin
          skip--;
        end else if (s == 3'b000) begin
          zrun++;
          if (zrun == DB + 1) armed = 1'b1;
        end else begin
          zrun = 0;
        end
        m_busy = !armed || run > 0;
      end
    end
  end

  initial begin : compare
    logic prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      check("choice_valid", choice_valid, m_valid);
      check("choice", choice, m_choice);
      check("choice_reject", choice_reject, m_reject);
      check("busy", busy, m_busy);
      if (choice_valid) begin
        valid_cnt++;
        last_valid_cyc = cyc;
      end
      if (choice_reject) reject_cnt++;
      if (prev_busy && !busy && !rst) busy_fall_cyc = cyc;
      prev_busy = busy;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin : stim
    int t0;
    int n0;
    int r0;

    step(3);
    check("rst_valid", choice_valid, 0);
    check("rst_choice", choice, 0);
    check("rst_reject", choice_reject, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    step(2);

    // Clean BTN2 press held 20 cycles
    btn2 = 1'b1; t0 = cyc; n0 = valid_cnt;
    step(20);
    check("s1_strobe_cycle", last_valid_cyc - t0, 7);
    check("s1_choice", choice, 2);
    check("s1_busy_held", busy, 1);
    btn2 = 1'b0;
    step(10);
    check("s1_strobes", valid_cnt - n0, 1);
    check("s1_busy_fall", busy_fall_cyc - t0, 27);

    // BTN1 bounce: 1 high, 1 low, then steady high
    n0 = valid_cnt;
    btn1 = 1'b1; step(1);
    btn1 = 1'b0; step(1);
    btn1 = 1'b1; t0 = cyc;
    step(15);
    check("s2_strobe_cycle", last_valid_cyc - t0, 7);
    check("s2_choice", choice, 1);
    check("s2_strobes", valid_cnt - n0, 1);
    btn1 = 1'b0;
    step(12);

    // BTN1 + BTN3 together
    n0 = valid_cnt; r0 = reject_cnt;
    btn1 = 1'b1; btn3 = 1'b1;
    step(15);
    check("s3_choice", choice, RejectEn ? 1 : 3);
    check("s3_valids", valid_cnt - n0, RejectEn ? 0 : 1);
    check("s3_rejects", reject_cnt - r0, RejectEn ? 1 : 0);
    btn1 = 1'b0; btn3 = 1'b0;
    step(12);

    // Hold BTN3, short 2-cycle release, press again: one strobe only
    n0 = valid_cnt;
    btn3 = 1'b1; step(15);
    btn3 = 1'b0; step(2);
    btn3 = 1'b1; step(15);
    btn3 = 1'b0; step(12);
    check("s4_strobes", valid_cnt - n0, 1);
    check("s4_choice", choice, 3);

    // Full release then BTN1 press: second strobe
    btn1 = 1'b1; step(15);
    btn1 = 1'b0; step(12);
    check("s5_strobes", valid_cnt - n0, 2);
    check("s5_choice", choice, 1);

    // Reset during DB_PRESS with BTN2 held
    btn2 = 1'b1;
    step(5);
    check("s6_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    check("s6_rst_valid", choice_valid, 0);
    check("s6_rst_choice", choice, 0);
    check("s6_rst_reject", choice_reject, 0);
    check("s6_rst_busy", busy, 0);
    step(2);
    rst = 1'b0; t0 = cyc; n0 = valid_cnt;
    step(12);
    check("s6_strobe_cycle", last_valid_cyc - t0, 7);
    check("s6_choice", choice, 2);
    check("s6_strobes", valid_cnt - n0, 1);
    btn2 = 1'b0;
    step(12);
    check("s6_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
